inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//  Upstream producer for the front fetch stage. Owns the fetch PC, issues sequential
//  requests to instruction memory, buffers in-order responses in a FIFO, and presents
//  {inst_o, instAddr_o} to the front fetch unit over a valid/ready handshake.
//  A jump redirect flushes the queue, discards stale in-flight responses and restarts
//  fetch at the jump target.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC after reset
//  DEPTH     4              FIFO entries; also caps occupancy+in-flight requests (power of 2, >=2)
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  reset_n          in   1   synchronous, active-low reset
//  jumpFlag_i       in   1   redirect strobe (one cycle)
//  jumpAddr_i       in   32  redirect target, word aligned
//  instReq_o        out  1   memory request valid
//  instReqAddr_o    out  32  memory request address (= fetch PC)
//  instReqReady_i   in   1   memory accepts request this cycle
//  instRspValid_i   in   1   memory response valid (in order, no backpressure)
//  instRspData_i    in   32  memory response instruction
//  valid_o          out  1   head entry valid to front fetch unit
//  ready_i          in   1   front fetch unit accepts head
//  inst_o           out  32  head instruction
//  instAddr_o       out  32  head instruction address
// BEHAVIOUR
//  State: pc, rspPc (address of next live response), FIFO occ, outCnt (live in-flight),
//   dropCnt (stale in-flight). Counters are clog2(DEPTH)+1 bits.
//  Reset (reset_n=0 at posedge): pc=rspPc=RESET_PC, occ=outCnt=dropCnt=0. Memory is
//   reset with this block, so no responses from pre-reset requests arrive.
//   Reset outputs: instReq_o=0, valid_o=0, inst_o=0, instAddr_o=0.
//  Credit: credit = (occ+outCnt+dropCnt < DEPTH).
//  Request: instReq_o = credit & ~jumpFlag_i. instReqAddr_o = pc (combinational).
//  Handshake: a request is accepted when instReq_o & instReqReady_i; then pc+=4, outCnt+=1.
//   pc wraps modulo 2^32.
//  Response, no jump this cycle:
//   - dropCnt>0: discard the response; dropCnt-=1.
//   - dropCnt=0: push {rspPc, data}; rspPc+=4; outCnt-=1.
//   FIFO never overflows by construction of credit.
//  Output: valid_o = (occ!=0) & ~jumpFlag_i; inst_o/instAddr_o = head entry
//   (0 when empty). Pop on valid_o & ready_i. Push and pop in the same cycle leave occ
//   unchanged. Push to an empty FIFO appears at the head the next cycle (1-cycle
//   response-to-valid latency).
//  Jump (jumpFlag_i=1), priority over all other events:
//   - Update: pc<=jumpAddr_i; rspPc<=jumpAddr_i; occ<=0 (no pop).
//   - dropCnt <= dropCnt + outCnt - instRspValid_i; outCnt<=0.
//     The response arriving in the jump cycle is discarded.
//   - First request to jumpAddr_i is issued the cycle after the jump, subject to credit.
//  Back-to-back jumps: each jump re-targets the PC, and stale counts accumulate.
//  A stalled memory (instReqReady_i=0) holds instReq_o and pc stable.
// TESTING
//  T1 reset, ready_i=1, mem 1-cycle latency returns data=addr^32'hA5A5_0000 ->
//   valid_o beats at instAddr_o 0,4,8,... one per cycle after the pipe fills;
//   inst_o matches the data.
//  T2 ready_i=0 held -> exactly DEPTH(4) requests issued; instReq_o then stays 0;
//   occ=4. Release ready_i -> entries 0x0..0xC drain in order, then requests resume at 0x10.
//  T3 jump to 0x100 with 2 requests in flight -> the next 2 responses are dropped;
//   the first valid_o shows instAddr_o=0x100.
//  T4 jump coincident with instRspValid_i and with valid_o&ready_i -> that response is
//   not pushed, valid_o=0 that cycle, and the FIFO is empty next cycle.
//  T5 jump 0x200 then jump 0x300 the next cycle, 3 in flight -> dropCnt=3;
//   no 0x200 entry ever appears; the first valid_o is at 0x300.
//  T6 reset_n low mid-stream with occ=3 -> next cycle valid_o=0, instReq_o=1,
//   instReqAddr_o=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch queue bundle: redirect, memory req/rsp, head-of-queue handshake
interface inst_fetch_queue_if;
    logic        jumpFlag_i;
    logic [31:0] jumpAddr_i;
    logic        instReq_o;
    logic [31:0] instReqAddr_o;
    logic        instReqReady_i;
    logic        instRspValid_i;
    logic [31:0] instRspData_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic [31:0] instAddr_o;

    modport master (
        input  jumpFlag_i, jumpAddr_i, instReqReady_i, instRspValid_i, instRspData_i, ready_i,
        output instReq_o, instReqAddr_o, valid_o, inst_o, instAddr_o
    );

    modport slave (
        output jumpFlag_i, jumpAddr_i, instReqReady_i, instRspValid_i, instRspData_i, ready_i,
        input  instReq_o, instReqAddr_o, valid_o, inst_o, instAddr_o
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - sequential fetch PC, credit-limited memory requests, in-order response FIFO
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    inst_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] occ;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];

    logic [CW+1:0] in_use;
    logic          credit;
    logic          jump;
    logic          req;
    logic          accept;
    logic          rsp_live;
    logic          rsp_drop;
    logic          head_valid;
    logic          pop;

    // Entries held plus every outstanding request (live or stale) must fit the FIFO.
    assign in_use     = {2'b00, occ} + {2'b00, out_cnt} + {2'b00, drop_cnt};
    assign credit     = in_use < (CW+2)'(DEPTH);
    assign jump       = bus.jumpFlag_i;
    assign req        = credit & ~jump;
    assign accept     = req & bus.instReqReady_i;
    assign rsp_live   = bus.instRspValid_i & ~jump & (drop_cnt == '0);
    assign rsp_drop   = bus.instRspValid_i & ~jump & (drop_cnt != '0);
    assign head_valid = (occ != '0) & ~jump;
    assign pop        = head_valid & bus.ready_i;

    // Handshake outputs are held low while reset is asserted.
    assign bus.instReq_o     = req & reset_n;
    assign bus.instReqAddr_o = pc;
    assign bus.valid_o       = head_valid & reset_n;
    assign bus.inst_o        = (reset_n && occ != '0) ? fifo_data[rd_ptr] : 32'h0;
    assign bus.instAddr_o    = (reset_n && occ != '0) ? fifo_addr[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            occ      <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (jump) begin
            // Live in-flight requests become stale; the response arriving now is consumed here.
            pc       <= bus.jumpAddr_i;
            rsp_pc   <= bus.jumpAddr_i;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= drop_cnt + out_cnt - CW'(bus.instRspValid_i);
            out_cnt  <= '0;
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
            end
            out_cnt <= out_cnt + CW'(accept) - CW'(rsp_live);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (rsp_live) begin
                wr_ptr <= wr_ptr + AW'(1);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ + CW'(rsp_live) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && rsp_live) begin
            fifo_addr[wr_ptr] <= rsp_pc;
            fifo_data[wr_ptr] <= bus.instRspData_i;
        end
    end
endmodule
